// File: rtl/traffic_light_controller_if.sv
// traffic_light_controller_if: lamp outputs and tick strobe of the intersection controller
interface traffic_light_controller_if;
    logic tick;
    logic ns_g;
    logic ns_y;
    logic ns_r;
    logic ew_g;
    logic ew_y;
    logic ew_r;
    modport master(output tick, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r);
    modport slave(input tick, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r);
endinterface

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: two-phase NS/EW light controller driven by a clock-divided tick
module tick_prescaler #(
    parameter int DIV = 20
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end
endmodule

module traffic_light #(
    parameter int NS_G_T = 5,
    parameter int NS_Y_T = 2,
    parameter int EW_G_T = 5,
    parameter int EW_Y_T = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r
);
    localparam int MAX_NS = NS_G_T > NS_Y_T ? NS_G_T : NS_Y_T;
    localparam int MAX_EW = EW_G_T > EW_Y_T ? EW_G_T : EW_Y_T;
    localparam int MAX_T = MAX_NS > MAX_EW ? MAX_NS : MAX_EW;
    localparam int TW = MAX_T > 1 ? $clog2(MAX_T) : 1;
    typedef enum logic [1:0] {NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW} state_t;
    state_t state, state_n, nxt;
    logic [TW-1:0] timer, timer_n, lim;
    logic [5:0] lamps, lamps_n;
    logic valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NS_GREEN;
            timer <= '0;
            lamps <= 6'b100001;
        end else begin
            state <= state_n;
            timer <= timer_n;
            lamps <= lamps_n;
        end
    end
    always_comb begin
        state_n = state;
        timer_n = timer;
        nxt = NS_GREEN;
        lim = '0;
        valid = 1'b1;
        case (state)
            NS_GREEN:  begin nxt = NS_YELLOW; lim = TW'(NS_G_T - 1); end
            NS_YELLOW: begin nxt = EW_GREEN;  lim = TW'(NS_Y_T - 1); end
            EW_GREEN:  begin nxt = EW_YELLOW; lim = TW'(EW_G_T - 1); end
            EW_YELLOW: begin nxt = NS_GREEN;  lim = TW'(EW_Y_T - 1); end
            default:   valid = 1'b0;
        endcase
        if (!valid) begin
            state_n = NS_GREEN;
            timer_n = '0;
        end else if (tick) begin
            state_n = timer == lim ? nxt : state;
            timer_n = timer == lim ? '0 : timer + TW'(1);
        end
        // lamps decode from the next state so they change on the same edge as the state
        lamps_n = state_n == NS_GREEN  ? 6'b100001 :
                  state_n == NS_YELLOW ? 6'b010001 :
                  state_n == EW_GREEN  ? 6'b001100 : 6'b001010;
    end
    assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = lamps;
endmodule

module traffic_light_controller #(
    parameter int DIV = 20,
    parameter int NS_G_T = 5,
    parameter int NS_Y_T = 2,
    parameter int EW_G_T = 5,
    parameter int EW_Y_T = 2
) (
    input logic clk,
    input logic rst,
    traffic_light_controller_if.master lights
);
    logic tick;
    tick_prescaler #(.DIV(DIV)) u_pre (
        .clk(clk),
        .rst(rst),
        .tick(tick)
    );
    traffic_light #(
        .NS_G_T(NS_G_T),
        .NS_Y_T(NS_Y_T),
        .EW_G_T(EW_G_T),
        .EW_Y_T(EW_Y_T)
    ) u_fsm (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .ns_g(lights.ns_g),
        .ns_y(lights.ns_y),
        .ns_r(lights.ns_r),
        .ew_g(lights.ew_g),
        .ew_y(lights.ew_y),
        .ew_r(lights.ew_r)
    );
    assign lights.tick = tick;
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed checks of tick timing, phase sequence, resets and DIV=1 corner
module tb_traffic_light_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    always #5 clk = ~clk;

    traffic_light_controller_if lt();
    traffic_light_controller_if lc();

    traffic_light_controller dut (
        .clk(clk),
        .rst(rst),
        .lights(lt)
    );
    traffic_light_controller #(
        .DIV(1), .NS_G_T(1), .NS_Y_T(1), .EW_G_T(1), .EW_Y_T(1)
    ) dut_c (
        .clk(clk),
        .rst(rst),
        .lights(lc)
    );

    logic [5:0] lamps_t, lamps_c;
    assign lamps_t = {lt.ns_g, lt.ns_y, lt.ns_r, lt.ew_g, lt.ew_y, lt.ew_r};
    assign lamps_c = {lc.ns_g, lc.ns_y, lc.ns_r, lc.ew_g, lc.ew_y, lc.ew_r};

    localparam logic [5:0] L_NSG = 6'b100001;
    localparam logic [5:0] L_NSY = 6'b010001;
    localparam logic [5:0] L_EWG = 6'b001100;
    localparam logic [5:0] L_EWY = 6'b001010;

    // ticks sampled up to edge n is floor((n-1)/div); phase follows from position in the cycle
    function automatic logic [5:0] model(int n, int div, int g1, int y1, int g2, int y2);
        int k, m;
        k = n >= 1 ? (n - 1) / div : 0;
        m = k % (g1 + y1 + g2 + y2);
        return m < g1 ? L_NSG : m < g1 + y1 ? L_NSY : m < g1 + y1 + g2 ? L_EWG : L_EWY;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (lamps_t !== L_NSG) begin
                failures++;
                $display("FAIL reset_lamps edge=%0d got=%b exp=%b", i, lamps_t, L_NSG);
            end
            checks++;
            if (lt.tick !== 1'b0) begin
                failures++;
                $display("FAIL reset_tick edge=%0d got=%b exp=0", i, lt.tick);
            end
        end
    endtask

    task automatic test_tick_period();
        int ticks = 0;
        rst = 1'b0;
        edge_n = 0;
        for (int n = 1; n <= 100; n++) begin
            step();
            edge_n = n;
            ticks += int'(lt.tick === 1'b1);
            checks++;
            if (lt.tick !== (n % 20 == 0)) begin
                failures++;
                $display("FAIL tick_period edge=%0d got=%b exp=%b", n, lt.tick, n % 20 == 0);
            end
            checks++;
            if (lamps_t !== model(n, 20, 5, 2, 5, 2)) begin
                failures++;
                $display("FAIL tick_lamps edge=%0d got=%b exp=%b", n, lamps_t, model(n, 20, 5, 2, 5, 2));
            end
        end
        checks++;
        if (ticks != 5) begin
            failures++;
            $display("FAIL tick_count got=%0d exp=5", ticks);
        end
    endtask

    task automatic test_full_sequence();
        logic [5:0] prev;
        prev = lamps_t;
        for (int n = edge_n + 1; n <= 840; n++) begin
            step();
            edge_n = n;
            checks++;
            if (lamps_t !== model(n, 20, 5, 2, 5, 2)) begin
                failures++;
                $display("FAIL seq_lamps edge=%0d got=%b exp=%b", n, lamps_t, model(n, 20, 5, 2, 5, 2));
            end
            if (lamps_t !== prev) begin
                checks++;
                if (!((n % 280) inside {1, 101, 141, 241})) begin
                    failures++;
                    $display("FAIL seq_transition edge=%0d got=%b prev=%b exp=no_change", n, lamps_t, prev);
                end
            end
            checks++;
            if (!$onehot(lamps_t[5:3]) || !$onehot(lamps_t[2:0]) ||
                ((lt.ns_g | lt.ns_y) & (lt.ew_g | lt.ew_y))) begin
                failures++;
                $display("FAIL seq_invariant edge=%0d got=%b exp=one_lamp_per_dir_no_conflict", n, lamps_t);
            end
            prev = lamps_t;
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 1; n < 200; n++) step();
        checks++;
        if (lamps_t !== L_EWG) begin
            failures++;
            $display("FAIL mid_pre_state got=%b exp=%b", lamps_t, L_EWG);
        end
        rst = 1'b1;
        step();
        checks++;
        if (lamps_t !== L_NSG || lt.tick !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%b tick=%b exp=%b tick=0", lamps_t, lt.tick, L_NSG);
        end
        rst = 1'b0;
        for (int n = 1; n <= 101; n++) begin
            step();
            checks++;
            if (lamps_t !== model(n, 20, 5, 2, 5, 2) || lt.tick !== (n % 20 == 0)) begin
                failures++;
                $display("FAIL mid_after edge=%0d got=%b tick=%b exp=%b tick=%b", n, lamps_t, lt.tick,
                         model(n, 20, 5, 2, 5, 2), n % 20 == 0);
            end
        end
    endtask

    task automatic test_reset_tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 1; n <= 100; n++) step();
        checks++;
        if (lt.tick !== 1'b1 || lamps_t !== L_NSG) begin
            failures++;
            $display("FAIL rt_pre got=%b tick=%b exp=%b tick=1", lamps_t, lt.tick, L_NSG);
        end
        rst = 1'b1;
        step();
        checks++;
        if (lamps_t !== L_NSG || lt.tick !== 1'b0) begin
            failures++;
            $display("FAIL rt_reset got=%b tick=%b exp=%b tick=0", lamps_t, lt.tick, L_NSG);
        end
        rst = 1'b0;
        for (int n = 1; n <= 101; n++) begin
            step();
            checks++;
            if (lamps_t !== model(n, 20, 5, 2, 5, 2)) begin
                failures++;
                $display("FAIL rt_after edge=%0d got=%b exp=%b", n, lamps_t, model(n, 20, 5, 2, 5, 2));
            end
        end
    endtask

    task automatic test_corner();
        rst = 1'b1;
        step();
        checks++;
        if (lamps_c !== L_NSG || lc.tick !== 1'b0) begin
            failures++;
            $display("FAIL corner_reset got=%b tick=%b exp=%b tick=0", lamps_c, lc.tick, L_NSG);
        end
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            checks++;
            if (lamps_c !== model(n, 1, 1, 1, 1, 1) || lc.tick !== 1'b1) begin
                failures++;
                $display("FAIL corner edge=%0d got=%b tick=%b exp=%b tick=1", n, lamps_c, lc.tick,
                         model(n, 1, 1, 1, 1, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_period();
        test_full_sequence();
        test_reset_mid();
        test_reset_tick();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Two-phase intersection traffic-light controller (north–south vs. east–west) for the board-level demo.
- A `tick_prescaler` stage divides the system clock into a one-cycle `tick` strobe.
- A `traffic_light` Moore FSM advances through the green/yellow phases, counting ticks per phase.
- This top level instantiates both, exposes the lamp outputs, and brings out `tick` for observation.

## Interface
Parameters:
- `DIV`, default 20: clock cycles per tick; legal range ≥ 1.
- `NS_G_T`, default 5: NS green duration in ticks; ≥ 1.
- `NS_Y_T`, default 2: NS yellow duration in ticks; ≥ 1.
- `EW_G_T`, default 5: EW green duration in ticks; ≥ 1.
- `EW_Y_T`, default 2: EW yellow duration in ticks; ≥ 1.

Ports:
- `clk`  in  1  the single system clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tick`  out  1  prescaler strobe, high for exactly one clk cycle per period.
- `ns_g`, `ns_y`, `ns_r`  out  1 each  north–south green, yellow and red lamps.
- `ew_g`, `ew_y`, `ew_r`  out  1 each  east–west green, yellow and red lamps.

## Operation
Prescaler:
- Counter `cnt`, width `$clog2(DIV)` (minimum 1).
- On each non-reset edge:
  - if `cnt == DIV-1`: `cnt <= 0`, `tick <= 1`;
  - else: `cnt <= cnt + 1`, `tick <= 0`.
- `DIV = 1` gives `tick` high on every cycle after reset.

FSM states: `NS_GREEN`, `NS_YELLOW`, `EW_GREEN`, `EW_YELLOW`.
- Phase timer width is sized for the largest `*_T`.
- On an edge with `tick == 1`:
  - if `timer == T_state - 1`: go to the next state and clear `timer` to 0;
  - else: `timer <= timer + 1`.
- With `tick == 0`, state and timer hold.
- Sequence: `NS_GREEN` → `NS_YELLOW` → `EW_GREEN` → `EW_YELLOW` → `NS_GREEN`, repeating.
- Each state lasts exactly its `T` ticks.

Lamp decode (registered, and updated on the same edge as the state):
- `NS_GREEN`: `ns_g = 1`, `ew_r = 1`.
- `NS_YELLOW`: `ns_y = 1`, `ew_r = 1`.
- `EW_GREEN`: `ew_g = 1`, `ns_r = 1`.
- `EW_YELLOW`: `ew_y = 1`, `ns_r = 1`.
- All other lamps are 0.

Invariants:
- Exactly one lamp is lit per direction, every cycle.
- Never green or yellow on both directions at once.
- An unreachable state encoding recovers to `NS_GREEN` with `timer = 0` on the next edge.

## Timing
- Reset (any edge with `rst = 1`, including mid-cycle):
  - `cnt = 0`, `tick = 0`;
  - state `NS_GREEN`, `timer = 0`;
  - `ns_g = 1`, `ew_r = 1`, all other lamps 0.
- Reset takes effect on that edge and overrides any tick in the same cycle.
- Edge numbering: count non-reset edges after reset release, starting at 1.
  - `tick` is high after edges DIV, 2·DIV, 3·DIV, …
  - The FSM samples each tick one edge later (edges DIV+1, 2·DIV+1, …).
- State entry edges, for the defaults (DIV = 20, 5/2/5/2):
  - `NS_YELLOW` at edge 101;
  - `EW_GREEN` at edge 141;
  - `EW_YELLOW` at edge 241;
  - `NS_GREEN` at edge 281.
- Full cycle = DIV·(NS_G_T + NS_Y_T + EW_G_T + EW_Y_T) = 280 clk cycles, periodic thereafter.
- Latency from a tick being sampled to the lamp change: 0 extra cycles (same edge).

## Test plan
- Reset values:
  - Stimulus: hold `rst = 1` for 2 edges.
  - Required response: `ns_g = 1`, `ew_r = 1`, `tick = 0`, all other lamps 0; `tick` stays 0 while `rst` is held.
- Tick period:
  - Stimulus: DIV = 20, release reset, run 100 edges.
  - Required response: `tick` high exactly 5 times, at edges 20/40/60/80/100, each one cycle wide.
- Full sequence:
  - Stimulus: defaults, run 840 edges (3 full cycles).
  - Required response: lamp transitions at edges 101, 141, 241, 281, and every +280 after that.
  - Every cycle: exactly one of g/y/r per direction, and never `ns_g|ns_y` together with `ew_g|ew_y`.
- Reset mid-operation:
  - Stimulus: assert `rst` for one edge during `EW_GREEN` (e.g. edge 200).
  - Required response: immediate return to `ns_g = 1`/`ew_r = 1` with `cnt = 0`.
  - The next transition occurs 101 non-reset edges after release.
- Reset coincident with tick:
  - Stimulus: assert `rst` on the edge where `tick = 1` is sampled.
  - Required response: no state advance; reset values result.
- Parameter corner:
  - Stimulus: DIV = 1, all `T = 1`.
  - Required response: the state advances on every edge from edge 2 onward, cycling all four phases every 4 cycles.
